// File: rtl/keypad_scanner_if.sv
// Signal bundle between the 4x4 key matrix / key consumer and keypad_scanner.
// The master side is the scanner: it reads the columns and drives rows and key status.
interface keypad_scanner_if;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_pulse;
    logic       key_held;
    logic       multi_key;

    modport master (
        input  col_in,
        output row_out,
        output key_code,
        output key_pulse,
        output key_held,
        output multi_key
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_code,
        input  key_pulse,
        input  key_held,
        input  multi_key
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner: one row driven low at a time, whole-frame
// debounce, and committed key events (code, one-shot pulse, held, multi-key).
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic                clk,
    input  logic                rst,
    keypad_scanner_if.master    bus
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_TOP  = DEB_W'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } row_e;

    typedef struct packed {
        logic       pressed;
        logic [3:0] code;
        logic       multi;
    } frame_res_t;

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [DIV_W-1:0] div_q, div_d;
    row_e             row_q, row_d;
    logic [15:0]      frame_q, frame_d;
    frame_res_t       prev_q, prev_d;
    logic [DEB_W-1:0] stab_q, stab_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_held_q, key_held_d;
    logic             multi_key_q, multi_key_d;
    logic             key_pulse_q, key_pulse_d;

    logic [15:0]      frame_cur;
    frame_res_t       cur_res;
    logic             commit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            div_q       <= '0;
            row_q       <= ROW0;
            frame_q     <= '0;
            prev_q      <= '0;
            stab_q      <= '0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            multi_key_q <= 1'b0;
            key_pulse_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            div_q       <= div_d;
            row_q       <= row_d;
            frame_q     <= frame_d;
            prev_q      <= prev_d;
            stab_q      <= stab_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            multi_key_q <= multi_key_d;
            key_pulse_q <= key_pulse_d;
        end
    end

    always_comb begin
        sync1_d     = bus.col_in;
        sync2_d     = sync1_q;
        div_d       = div_q + DIV_W'(1);
        row_d       = row_q;
        frame_d     = frame_q;
        prev_d      = prev_q;
        stab_d      = stab_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        multi_key_d = multi_key_q;
        key_pulse_d = 1'b0;
        frame_cur   = frame_q;
        cur_res     = '0;
        commit      = 1'b0;

        if (div_q == DIV_LAST) begin
            div_d = '0;
            for (int unsigned c = 0; c < 4; c++) begin
                if (!sync2_q[c]) begin
                    frame_cur[{row_q, c[1:0]}] = 1'b1;
                end
            end

            case (row_q)
                ROW0:    row_d = ROW1;
                ROW1:    row_d = ROW2;
                ROW2:    row_d = ROW3;
                default: row_d = ROW0;
            endcase

            if (row_q == ROW3) begin
                // Frame complete: reduce to {pressed, lowest code, multi} and debounce.
                cur_res.pressed = |frame_cur;
                cur_res.multi   = (frame_cur & (frame_cur - 16'd1)) != '0;
                for (int unsigned i = 16; i > 0; i--) begin
                    if (frame_cur[i-1]) begin
                        cur_res.code = 4'(i - 1);
                    end
                end
                frame_d = '0;

                if (cur_res == prev_q) begin
                    if (stab_q != DEB_TOP) begin
                        stab_d = stab_q + DEB_W'(1);
                        commit = (stab_q + DEB_W'(1)) == DEB_TOP;
                    end
                end else begin
                    stab_d = DEB_W'(1);
                    prev_d = cur_res;
                    commit = (DEBOUNCE_FRAMES == 1);
                end

                if (commit) begin
                    if (cur_res.pressed) begin
                        multi_key_d = cur_res.multi;
                        if (!key_held_q || (cur_res.code != key_code_q)) begin
                            key_code_d  = cur_res.code;
                            key_held_d  = 1'b1;
                            key_pulse_d = 1'b1;
                        end
                    end else begin
                        key_held_d  = 1'b0;
                        multi_key_d = 1'b0;
                    end
                end
            end else begin
                frame_d = frame_cur;
            end
        end
    end

    always_comb begin
        case (row_q)
            ROW0:    bus.row_out = 4'b1110;
            ROW1:    bus.row_out = 4'b1101;
            ROW2:    bus.row_out = 4'b1011;
            default: bus.row_out = 4'b0111;
        endcase
    end

    assign bus.key_code  = key_code_q;
    assign bus.key_pulse = key_pulse_q;
    assign bus.key_held  = key_held_q;
    assign bus.multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] keys;
    logic        raw_en;
    logic [3:0]  raw_cols;
    logic [3:0]  mat_cols;
    int          n_cmp;
    int          n_err;
    int          pulse_total;
    logic [3:0]  pulse_code;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix: a pressed key ties its column low while its row is driven low.
    always_comb begin
        mat_cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (kif.row_out[r] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) mat_cols[c] = 1'b0;
                end
            end
        end
        kif.col_in = raw_en ? raw_cols : mat_cols;
    end

    initial begin
        pulse_total = 0;
        pulse_code  = '0;
    end

    always @(negedge clk) begin
        if (kif.key_pulse === 1'b1) begin
            pulse_total = pulse_total + 1;
            pulse_code  = kif.key_code;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] exp_row;
        rst      = 1'b0;
        raw_en   = 1'b1;
        raw_cols = 4'b0000;
        tick(3);
        n_cmp++; if (kif.row_out !== 4'b1110) begin n_err++; $display("FAIL reset_row got=%b exp=1110", kif.row_out); end
        n_cmp++; if (kif.key_code !== 4'd0) begin n_err++; $display("FAIL reset_code got=%0d exp=0", kif.key_code); end
        n_cmp++; if (kif.key_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse got=%b exp=0", kif.key_pulse); end
        n_cmp++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL reset_held got=%b exp=0", kif.key_held); end
        n_cmp++; if (kif.multi_key !== 1'b0) begin n_err++; $display("FAIL reset_multi got=%b exp=0", kif.multi_key); end
        rst    = 1'b1;
        raw_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            n_cmp++;
            if (kif.row_out !== exp_row) begin
                n_err++;
                $display("FAIL row_seq cycle=%0d got=%b exp=%b", i, kif.row_out, exp_row);
            end
            tick(1);
        end
    endtask

    task automatic test_single_press;
        int base;
        base = pulse_total;
        keys = 16'h0040;
        tick(80);
        n_cmp++; if (pulse_total - base !== 1) begin n_err++; $display("FAIL single_pulses got=%0d exp=1", pulse_total - base); end
        n_cmp++; if (pulse_code !== 4'd6) begin n_err++; $display("FAIL single_pulse_code got=%0d exp=6", pulse_code); end
        n_cmp++; if (kif.key_code !== 4'd6) begin n_err++; $display("FAIL single_code got=%0d exp=6", kif.key_code); end
        n_cmp++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL single_held got=%b exp=1", kif.key_held); end
        n_cmp++; if (kif.multi_key !== 1'b0) begin n_err++; $display("FAIL single_multi got=%b exp=0", kif.multi_key); end
        keys = '0;
        tick(64);
        n_cmp++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL release_held got=%b exp=0", kif.key_held); end
        n_cmp++; if (kif.key_code !== 4'd6) begin n_err++; $display("FAIL release_code got=%0d exp=6", kif.key_code); end
        n_cmp++; if (pulse_total - base !== 1) begin n_err++; $display("FAIL release_pulses got=%0d exp=1", pulse_total - base); end
    endtask

    task automatic test_bounce;
        int base;
        int guard;
        base  = pulse_total;
        guard = 0;
        while (kif.row_out !== 4'b0111 && guard < 100) begin tick(1); guard++; end
        while (kif.row_out !== 4'b1110 && guard < 100) begin tick(1); guard++; end
        n_cmp++; if (guard >= 100) begin n_err++; $display("FAIL bounce_align got=timeout exp=frame_start"); end
        for (int k = 0; k < 40; k++) begin
            keys[9] = ((k / 6) % 2) == 0;
            tick(1);
        end
        keys[9] = 1'b1;
        n_cmp++; if (pulse_total - base !== 0) begin n_err++; $display("FAIL bounce_early got=%0d exp=0", pulse_total - base); end
        tick(64);
        n_cmp++; if (pulse_total - base !== 1) begin n_err++; $display("FAIL bounce_pulses got=%0d exp=1", pulse_total - base); end
        n_cmp++; if (kif.key_code !== 4'd9) begin n_err++; $display("FAIL bounce_code got=%0d exp=9", kif.key_code); end
        n_cmp++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL bounce_held got=%b exp=1", kif.key_held); end
        keys = '0;
        tick(64);
    endtask

    task automatic test_multi_key;
        int base;
        base = pulse_total;
        keys = 16'h1008;
        tick(80);
        n_cmp++; if (pulse_total - base !== 1) begin n_err++; $display("FAIL multi_pulses got=%0d exp=1", pulse_total - base); end
        n_cmp++; if (kif.key_code !== 4'd3) begin n_err++; $display("FAIL multi_code got=%0d exp=3", kif.key_code); end
        n_cmp++; if (kif.multi_key !== 1'b1) begin n_err++; $display("FAIL multi_flag got=%b exp=1", kif.multi_key); end
        keys = 16'h1000;
        tick(80);
        n_cmp++; if (pulse_total - base !== 2) begin n_err++; $display("FAIL rollover_pulses got=%0d exp=2", pulse_total - base); end
        n_cmp++; if (pulse_code !== 4'd12) begin n_err++; $display("FAIL rollover_pulse_code got=%0d exp=12", pulse_code); end
        n_cmp++; if (kif.multi_key !== 1'b0) begin n_err++; $display("FAIL rollover_multi got=%b exp=0", kif.multi_key); end
        n_cmp++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL rollover_held got=%b exp=1", kif.key_held); end
        keys = '0;
        tick(64);
    endtask

    task automatic test_glitch;
        int base;
        base = pulse_total;
        keys = 16'h0001;
        tick(10);
        keys = '0;
        tick(64);
        n_cmp++; if (pulse_total - base !== 0) begin n_err++; $display("FAIL glitch_pulses got=%0d exp=0", pulse_total - base); end
        n_cmp++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL glitch_held got=%b exp=0", kif.key_held); end
    endtask

    task automatic test_reset_mid;
        int base;
        logic exp_p;
        keys = 16'h0020;
        tick(80);
        n_cmp++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL pre_rst_held got=%b exp=1", kif.key_held); end
        n_cmp++; if (kif.key_code !== 4'd5) begin n_err++; $display("FAIL pre_rst_code got=%0d exp=5", kif.key_code); end
        rst = 1'b0;
        tick(1);
        n_cmp++; if (kif.row_out !== 4'b1110) begin n_err++; $display("FAIL mid_rst_row got=%b exp=1110", kif.row_out); end
        n_cmp++; if (kif.key_code !== 4'd0) begin n_err++; $display("FAIL mid_rst_code got=%0d exp=0", kif.key_code); end
        n_cmp++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL mid_rst_held got=%b exp=0", kif.key_held); end
        n_cmp++; if (kif.multi_key !== 1'b0) begin n_err++; $display("FAIL mid_rst_multi got=%b exp=0", kif.multi_key); end
        n_cmp++; if (kif.key_pulse !== 1'b0) begin n_err++; $display("FAIL mid_rst_pulse got=%b exp=0", kif.key_pulse); end
        tick(2);
        rst  = 1'b1;
        base = pulse_total;
        // Two full frames from restart; commit on the edge ending cycle 31.
        for (int k = 0; k < 34; k++) begin
            if (k >= 31) begin
                exp_p = (k == 32);
                n_cmp++;
                if (kif.key_pulse !== exp_p) begin
                    n_err++;
                    $display("FAIL latency_pulse cycle=%0d got=%b exp=%b", k, kif.key_pulse, exp_p);
                end
            end
            tick(1);
        end
        n_cmp++; if (pulse_total - base !== 1) begin n_err++; $display("FAIL post_rst_pulses got=%0d exp=1", pulse_total - base); end
        n_cmp++; if (pulse_code !== 4'd5) begin n_err++; $display("FAIL post_rst_code got=%0d exp=5", pulse_code); end
        n_cmp++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL post_rst_held got=%b exp=1", kif.key_held); end
        keys = '0;
        tick(64);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b0;
        keys     = '0;
        raw_en   = 1'b1;
        raw_cols = 4'b0000;
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
